// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, in-order word fetch, redirect flush, decode queue.
// Ports: clk_i/arst_ni, redirect_i/_pc_i, req_*, rsp_*, instr_*, err_o.
module fetch_unit #(
   parameter int unsigned    DPW      = 32,
   parameter logic [DPW-1:0] RESET_PC = '0,
   parameter int unsigned    QDEPTH   = 2
) (
   input  logic           clk_i,
   input  logic           arst_ni,
   input  logic           redirect_i,
   input  logic [DPW-1:0] redirect_pc_i,
   output logic           req_valid_o,
   output logic [DPW-1:0] req_addr_o,
   input  logic           req_ready_i,
   input  logic           rsp_valid_i,
   input  logic [DPW-1:0] rsp_data_i,
   output logic           instr_valid_o,
   output logic [DPW-1:0] instr_o,
   output logic [DPW-1:0] instr_pc_o,
   input  logic           instr_ready_i,
   output logic           err_o
);

   localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

   state_t         state, state_nx;
   logic [DPW-1:0] pc, rsp_pc, tgt;
   logic [CW-1:0]  outstanding, drop_cnt, drop_nx, q_cnt;
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [DPW-1:0] q_instr [QDEPTH];
   logic [DPW-1:0] q_pc    [QDEPTH];
   logic           err_q;
   logic           redir, rsp_ok, drop, push, pop, hs, credit, q_ne;
   logic [CW:0]    inflight;

   assign redir    = redirect_i && (state != IDLE);
   assign tgt      = redirect_pc_i & ~DPW'(3);
   assign rsp_ok   = rsp_valid_i && (outstanding != '0);
   // a response in the redirect cycle is wrong-path, as is any during a drain
   assign drop     = rsp_ok && ((drop_cnt != '0) || redir);
   assign push     = rsp_ok && !drop;
   assign q_ne     = (q_cnt != '0);
   assign pop      = q_ne && instr_ready_i && !redir;
   assign inflight = {1'b0, outstanding} + {1'b0, q_cnt};
   // registered counts only: a granted request always has a queue slot
   assign credit   = 32'(inflight) < QDEPTH;
   assign hs       = req_valid_o && req_ready_i;

   always_comb begin
      drop_nx = drop_cnt;
      if (redir)
         drop_nx = outstanding - CW'(rsp_ok);
      else if (drop)
         drop_nx = drop_cnt - CW'(1);
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = FETCH;
         FETCH:   if (redir && (drop_nx != '0)) state_nx = FLUSH;
         FLUSH:   if (drop_nx == '0) state_nx = FETCH;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_valid_o   = (state == FETCH) && !redirect_i && credit;
      req_addr_o    = pc;
      instr_valid_o = q_ne;
      instr_o       = '0;
      instr_pc_o    = '0;
      if (q_ne) begin
         instr_o    = q_instr[rd_ptr];
         instr_pc_o = q_pc[rd_ptr];
      end
      err_o = err_q;
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         pc          <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q       <= rsp_valid_i && (outstanding == '0);
         drop_cnt    <= drop_nx;
         outstanding <= outstanding + CW'(hs) - CW'(rsp_ok);
         if (redir) begin
            pc     <= tgt;
            rsp_pc <= tgt;
         end else begin
            if (hs)   pc     <= pc + DPW'(4);
            if (push) rsp_pc <= rsp_pc + DPW'(4);
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         q_cnt  <= '0;
      end else if (redir) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         q_cnt  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         q_cnt <= q_cnt + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         q_instr[wr_ptr] <= rsp_data_i;
         q_pc[wr_ptr]    <= rsp_pc;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random + directed bench for fetch_unit.
// Memory model and program-stream scoreboard live in the bench.
module tb_fetch_unit;

   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        arst_ni = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        req_valid_o;
   logic [31:0] req_addr_o;
   logic        req_ready_i = 1'b0;
   logic        rsp_valid_i = 1'b0;
   logic [31:0] rsp_data_i = '0;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i = 1'b0;
   logic        err_o;

   fetch_unit #(.DPW(32), .RESET_PC(RPC), .QDEPTH(2)) dut (
      .clk_i(clk_i), .arst_ni(arst_ni),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .req_valid_o(req_valid_o), .req_addr_o(req_addr_o),
      .req_ready_i(req_ready_i),
      .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o),
      .instr_pc_o(instr_pc_o), .instr_ready_i(instr_ready_i),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   int          n_cmp = 0, n_bad = 0;
   int          cyc = 0, last_due = 0;
   int          n_hs = 0, n_pop = 0;
   int          lat_min = 1, lat_max = 1;
   logic        rdy_now = 0, ird_now = 0, redir_now = 0, force_rsp = 0;
   logic [31:0] redir_tgt = '0;
   logic [31:0] exp_req_pc, exp_pc, pend_addr, last_pop_pc;
   logic        exp_err = 0, pend = 0, idle_cyc = 1;
   logic        s_rvalid, s_ivalid, s_err;
   logic [31:0] s_addr, s_ipc;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // one clock: entered and left at a negedge
   task automatic cycle();
      logic        rv, reff;
      int          d;
      redirect_i    = redir_now;
      redirect_pc_i = redir_tgt;
      req_ready_i   = rdy_now;
      instr_ready_i = ird_now;
      rv            = 1'b0;
      rsp_data_i    = '0;
      if (force_rsp) begin
         rv         = 1'b1;
         rsp_data_i = 32'hBAD0_0BAD;
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
         rv         = 1'b1;
         rsp_data_i = mdata(mq[0].addr);
      end
      rsp_valid_i = rv;
      #1;
      reff = redir_now && !idle_cyc;
      s_err = err_o;
      chk("err", err_o, exp_err);
      exp_err = rv && (mq.size() == 0);
      if (rv && mq.size() > 0) void'(mq.pop_front());
      if (pend && !reff) begin
         chk("hold_v", req_valid_o, 1);
         chk("hold_a", req_addr_o, pend_addr);
      end
      if (req_valid_o && req_ready_i) begin
         chk("req_addr", req_addr_o, exp_req_pc);
         d = cyc + int'($urandom_range(lat_max, lat_min));
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         mq.push_back('{addr: req_addr_o, due: d});
         exp_req_pc += 32'd4;
         n_hs++;
      end
      pend      = req_valid_o && !req_ready_i;
      pend_addr = req_addr_o;
      if (reff) begin
         exp_req_pc = redir_tgt & ~32'd3;
         exp_pc     = redir_tgt & ~32'd3;
      end else if (instr_valid_o && instr_ready_i) begin
         chk("pop_pc", instr_pc_o, exp_pc);
         chk("pop_data", instr_o, mdata(exp_pc));
         last_pop_pc = instr_pc_o;
         exp_pc += 32'd4;
         n_pop++;
      end
      s_rvalid = req_valid_o;
      s_addr   = req_addr_o;
      s_ivalid = instr_valid_o;
      s_ipc    = instr_pc_o;
      idle_cyc = 1'b0;
      @(negedge clk_i);
      cyc++;
   endtask

   task automatic do_reset();
      arst_ni = 1'b0;
      redirect_i = 0; req_ready_i = 0; rsp_valid_i = 0; instr_ready_i = 0;
      redir_now = 0; force_rsp = 0; rdy_now = 0; ird_now = 0;
      #2;
      chk("rst_rv", req_valid_o, 0);
      chk("rst_ra", req_addr_o, RPC);
      chk("rst_iv", instr_valid_o, 0);
      chk("rst_io", instr_o, 0);
      chk("rst_ipc", instr_pc_o, 0);
      chk("rst_err", err_o, 0);
      mq.delete();
      last_due = cyc;
      exp_req_pc = RPC; exp_pc = RPC; exp_err = 0; pend = 0;
      idle_cyc = 1; n_hs = 0; n_pop = 0;
      @(negedge clk_i);
      arst_ni = 1'b1;
   endtask

   task automatic run_hs(input int n, input int budget);
      int k = 0;
      while (n_hs < n && k < budget) begin
         cycle();
         k++;
      end
      chk("hs_timeout", n_hs >= n, 1);
   endtask

   task automatic run_pop(input int n, input int budget);
      int k = 0;
      while (n_pop < n && k < budget) begin
         cycle();
         k++;
      end
      chk("pop_timeout", n_pop >= n, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int p0;
      @(negedge clk_i);

      // streaming with a 1-cycle memory
      do_reset();
      rdy_now = 1; ird_now = 1; lat_min = 1; lat_max = 1;
      cycle();
      chk("idle_noreq", s_rvalid, 0);
      cycle();
      chk("first_rv", s_rvalid, 1);
      chk("first_ra", s_addr, 32'h0);
      cycle();
      chk("lat_n1", s_ivalid, 0);
      cycle();
      chk("lat_n2", s_ivalid, 1);
      chk("lat_pc", s_ipc, 32'h0);
      run_pop(8, 40);

      // decode stalled: credit limits to two requests
      do_reset();
      rdy_now = 1; ird_now = 0;
      repeat (10) cycle();
      chk("cred_hs", n_hs, 2);
      chk("cred_rv", s_rvalid, 0);
      chk("cred_head", s_ipc, 32'h0);
      ird_now = 1;
      run_pop(4, 30);

      // memory stall, plus redirect in IDLE ignored
      do_reset();
      rdy_now = 0; ird_now = 1;
      redir_now = 1; redir_tgt = 32'h40;
      cycle();
      redir_now = 0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("stall_rv", s_rvalid, 1);
         chk("stall_ra", s_addr, 32'h0);
      end
      rdy_now = 1;
      cycle();
      chk("stall_hs", n_hs, 1);
      rdy_now = 0;
      cycle();
      chk("stall_pc4", s_addr, 32'h4);

      // redirect with two outstanding
      do_reset();
      rdy_now = 1; ird_now = 1; lat_min = 1; lat_max = 1;
      run_hs(2, 20);
      lat_min = 8; lat_max = 8;
      run_hs(4, 30);
      lat_min = 1; lat_max = 1;
      redir_now = 1; redir_tgt = 32'h103;
      cycle();
      redir_now = 0;
      cycle();
      chk("rd_qempty", s_ivalid, 0);
      p0 = n_pop;
      run_pop(p0 + 1, 40);
      chk("rd_first", last_pop_pc, 32'h100);
      run_pop(p0 + 4, 40);

      // redirect together with a response and a pop
      do_reset();
      rdy_now = 1; ird_now = 0;
      repeat (3) cycle();
      redir_now = 1; redir_tgt = 32'h200; ird_now = 1;
      cycle();
      chk("rr_head", s_ivalid, 1);
      redir_now = 0;
      cycle();
      chk("rr_empty", s_ivalid, 0);
      run_pop(1, 20);
      chk("rr_first", last_pop_pc, 32'h200);

      // stray response with nothing outstanding
      do_reset();
      rdy_now = 1; ird_now = 0;
      repeat (8) cycle();
      chk("err_hs", n_hs, 2);
      force_rsp = 1;
      cycle();
      force_rsp = 0;
      cycle();
      chk("err_hi", s_err, 1);
      cycle();
      chk("err_lo", s_err, 0);
      chk("err_qv", s_ivalid, 1);
      chk("err_qpc", s_ipc, 32'h0);
      ird_now = 1;
      run_pop(2, 20);

      // random traffic
      do_reset();
      lat_min = 1; lat_max = 4;
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] r;
         r = $urandom;
         rdy_now = ($urandom_range(9) < 7);
         ird_now = ($urandom_range(9) < 6);
         if (!redir_now && $urandom_range(19) == 0) begin
            redir_now = 1;
            if ($urandom_range(3) == 0)
               redir_tgt = 32'hFFFF_FFF0 | {28'h0, r[3:0]};
            else
               redir_tgt = r & 32'h0000_FFFF;
         end else begin
            redir_now = 0;
         end
         cycle();
      end
      redir_now = 0; ird_now = 1;
      repeat (20) cycle();
      chk("progress", n_pop > 100, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
